// File: rtl/decode_pkg.sv
// Shared decode-stage types: immediate format selects and the registered entry layout.
// Widths here are defaults for the single-cycle path; parametrised users rebuild the entry locally.
// No timing or flow control lives in this package.
package decode_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int TAG_W_DEF = 32;

    typedef enum logic [2:0] {
        IMM_I   = 3'd0,
        IMM_S   = 3'd1,
        IMM_B   = 3'd2,
        IMM_J   = 3'd3,
        IMM_U   = 3'd4,
        IMM_Z   = 3'd5,
        IMM_SH  = 3'd6,
        IMM_BAD = 3'd7
    } imm_src_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0]  imm;
        logic [TAG_W_DEF-1:0] tag;
        logic                 illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_format.sv
// Immediate extraction and extension for one instruction word.
// Latency 0 (purely combinational).
// No flow control; the caller owns any handshake.
module imm_format
    import decode_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [31:0]     ins,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // Built at 64 bits and truncated so RV32 and RV64 share one table.
    logic [63:0] imm_full;

    always_comb begin
        imm_full = '0;
        illegal  = 1'b0;
        case (imm_src_e'(imm_src))
            IMM_I:   imm_full = {{52{ins[31]}}, ins[31:20]};
            IMM_S:   imm_full = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm_full = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_J:   imm_full = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            IMM_U:   imm_full = {{32{ins[31]}}, ins[31:12], 12'b0};
            IMM_Z:   imm_full = {59'b0, ins[19:15]};
            IMM_SH:  imm_full = (XLEN == 64) ? {58'b0, ins[25:20]} : {59'b0, ins[24:20]};
            IMM_BAD: illegal  = 1'b1;
            default: illegal  = 1'b1;
        endcase
    end

    assign imm = imm_full[XLEN-1:0];

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator between decode and ID/EX with a 2-entry skid buffer.
// Latency 1 cycle; full throughput while out_ready is high.
// in_ready depends only on the skid register, so out_ready never reaches it combinationally.
module imm_gen_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      ins,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_op,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $fatal(1, "imm_gen_stage: XLEN must be 32 or 64");
        end
    endgenerate

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
    } entry_t;

    logic [XLEN-1:0] fmt_imm;
    logic            fmt_illegal;
    entry_t          new_entry;
    entry_t          main_q;
    entry_t          skid_q;
    logic            main_vld;
    logic            skid_vld;
    logic            accept;
    logic            main_free;

    imm_format #(.XLEN(XLEN)) u_imm_format (
        .ins     (ins),
        .imm_src (imm_src),
        .imm     (fmt_imm),
        .illegal (fmt_illegal)
    );

    assign new_entry = '{imm: fmt_imm, tag: in_tag, illegal: fmt_illegal};

    assign in_ready  = !skid_vld && !rst;
    assign accept    = in_valid && in_ready && !flush;
    assign main_free = !main_vld || out_ready;

    // Skid is only ever occupied while main is, so draining main always promotes skid first.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (main_free) begin
            if (skid_vld) begin
                main_q   <= skid_q;
                main_vld <= 1'b1;
                skid_vld <= 1'b0;
            end else if (accept) begin
                main_q   <= new_entry;
                main_vld <= 1'b1;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (accept) begin
            skid_q   <= new_entry;
            skid_vld <= 1'b1;
        end
    end

    assign out_valid = main_vld;
    assign imm_op    = main_q.imm;
    assign out_tag   = main_q.tag;
    assign illegal   = main_q.illegal;

endmodule
